dw_hazard_sequencer: RTL

- Decode-stage sequencer for the pipelined RISC core. Produces the `stall` input of the control unit, which makes it issue the two rounds of LDW (opcode 8) and SDW (opcode 9).
- Detects load-use hazards and inserts bubbles.
- Raises an exception when LDW/SDW uses an odd Rd.
- Drives the PC and IF/ID hold signals, and keeps a saturating stall-cycle counter for debug.

---
 rtl/dw_hazard_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/dw_hazard_sequencer.sv
// Decode-stage sequencer: issues the two rounds of LDW/SDW, inserts load-use bubbles,
// flags odd-Rd double-word instructions and counts PC hold cycles.
module dw_hazard_sequencer #(
  parameter int          CNT_W  = 16,
  parameter logic [5:0]  OP_LDW = 6'd8,
  parameter logic [5:0]  OP_SDW = 6'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic             stall,
  output logic             dw_round2,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             bubble,
  output logic             dw_exception,
  output logic             busy,
  output logic             state_dbg,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DW_R2 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic lu_hazard;
  logic is_dw;

  assign lu_hazard = id_valid & ex_memrd & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign is_dw     = id_valid & ((id_opcode == OP_LDW) | (id_opcode == OP_SDW));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are forced low while reset is held so the control unit sees a clean pipe.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    dw_round2    = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    bubble       = 1'b0;
    dw_exception = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (lu_hazard) begin
          bubble    = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end else if (is_dw && id_rd[0]) begin
          dw_exception = 1'b1;
          bubble       = 1'b1;
        end else if (is_dw) begin
          stall      = 1'b1;
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          state_next = DW_R2;
        end
      end
      DW_R2: begin
        // Round 2 reuses the base register already checked in round 1, so no hazard test here.
        busy       = 1'b1;
        state_next = IDLE;
        if (flush) begin
          bubble = 1'b1;
        end else begin
          dw_round2 = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      stall        = 1'b0;
      dw_round2    = 1'b0;
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      bubble       = 1'b0;
      dw_exception = 1'b0;
      busy         = 1'b0;
      state_next   = IDLE;
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (pc_hold && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
